// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetches one instruction word at a time from instruction memory and holds it
// until the downstream stage consumes it.
//
// Ports
//   CLK, resetl            clock and asynchronous active-low reset
//   startPC   [63:0] in    first fetch address, taken in LOAD
//   NextPC    [63:0] in    next fetch address, taken on advance in HOLD
//   advance          in    downstream consumed the held instruction
//   imem_req_valid   out   read request valid
//   imem_req_ready   in    memory accepts the request
//   imem_addr [63:0] out   request address (equals CurrentPC)
//   imem_rsp_valid   in    read data valid
//   imem_rsp_data [31:0] in read instruction word
//   CurrentPC [63:0] out   PC register
//   Instruction [31:0] out held instruction
//   instr_valid      out   high exactly while holding an instruction
//   misaligned       out   sticky: fetch attempted with PC[1:0] != 0
//   timeout          out   sticky: no memory response within the wait window
// ---------------------------------------------------------------------------
module instr_fetch_unit (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] startPC,
    input  logic [63:0] NextPC,
    input  logic        advance,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [63:0] CurrentPC,
    output logic [31:0] Instruction,
    output logic        instr_valid,
    output logic        misaligned,
    output logic        timeout
);

    localparam int unsigned CNT_W = 8;
    // Last wait cycle on which a response is still accepted; without one the
    // counter steps to 255 on this edge and the fetch faults.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(254);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [63:0]      pc_nxt;
    logic [31:0]      instr_nxt;
    logic             instr_valid_nxt;
    logic             req_valid_nxt;
    logic             misaligned_nxt;
    logic             timeout_nxt;

    // State and output registers
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state          <= S_LOAD;
            wait_cnt       <= '0;
            CurrentPC      <= '0;
            Instruction    <= '0;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b0;
            misaligned     <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_cnt_nxt;
            CurrentPC      <= pc_nxt;
            Instruction    <= instr_nxt;
            instr_valid    <= instr_valid_nxt;
            imem_req_valid <= req_valid_nxt;
            misaligned     <= misaligned_nxt;
            timeout        <= timeout_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        pc_nxt          = CurrentPC;
        instr_nxt       = Instruction;
        instr_valid_nxt = instr_valid;
        misaligned_nxt  = misaligned;
        timeout_nxt     = timeout;

        case (state)
            S_LOAD: begin
                pc_nxt    = startPC;
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (CurrentPC[1:0] != 2'b00) begin
                    misaligned_nxt = 1'b1;
                    state_nxt      = S_ERR;
                end else if (imem_req_ready) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response always wins over the timeout on the same edge
                if (imem_rsp_valid) begin
                    instr_nxt       = imem_rsp_data;
                    instr_valid_nxt = 1'b1;
                    state_nxt       = S_HOLD;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    if (wait_cnt == CNT_LAST) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (advance) begin
                    pc_nxt          = NextPC;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = S_REQ;
                end
            end
            S_ERR: begin
                instr_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_ERR;
            end
        endcase

        // Request is raised on entry to REQ, so it is valid for the whole REQ
        // stay and never raised for a misaligned PC.
        req_valid_nxt = (state_nxt == S_REQ) && (pc_nxt[1:0] == 2'b00);
    end

    assign imem_addr = CurrentPC;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. Each fetch is described by its
// handshake delays; expected outputs follow from those delays and the
// addresses/data the bench chose.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startPC;
    logic [63:0] NextPC;
    logic        advance;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        misaligned;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_pc;
    logic [31:0] exp_instr;

    instr_fetch_unit dut (
        .CLK            (CLK),
        .resetl         (resetl),
        .startPC        (startPC),
        .NextPC         (NextPC),
        .advance        (advance),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .CurrentPC      (CurrentPC),
        .Instruction    (Instruction),
        .instr_valid    (instr_valid),
        .misaligned     (misaligned),
        .timeout        (timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},     CurrentPC,      64'd0);
        check({tag, "_instr"},  Instruction,    64'd0);
        check({tag, "_ivalid"}, instr_valid,    64'd0);
        check({tag, "_reqv"},   imem_req_valid, 64'd0);
        check({tag, "_misal"},  misaligned,     64'd0);
        check({tag, "_tmo"},    timeout,        64'd0);
    endtask

    // Pulse reset, optionally with a stale response present, then release.
    // Returns just after the first edge after release (fetch at spc pending).
    task automatic do_reset(input logic [63:0] spc, input bit stale_rsp);
        resetl         = 1'b0;
        imem_req_ready = 1'b0;
        advance        = 1'b0;
        imem_rsp_valid = stale_rsp;
        imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        check_reset_values("rst_async");
        step();
        step();
        check_reset_values("rst_held");
        startPC = spc;
        resetl  = 1'b1;
        step();
        exp_pc    = spc;
        exp_instr = 32'd0;
        check("rst_rel_pc",     CurrentPC,   spc);
        check("rst_rel_instr",  Instruction, 64'd0);
        check("rst_rel_ivalid", instr_valid, 64'd0);
        imem_rsp_valid = 1'b0;
    endtask

    // One fetch: ready after rdy_wait low cycles, response after rsp_wait
    // idle wait cycles. Entered just after the edge that started the request.
    task automatic do_fetch(input int rdy_wait, input int rsp_wait, input logic [31:0] data);
        for (int i = 0; i <= rdy_wait; i++) begin
            check("req_valid",  imem_req_valid, 64'd1);
            check("req_addr",   imem_addr,      exp_pc);
            check("req_ivalid", instr_valid,    64'd0);
            imem_req_ready = (i == rdy_wait);
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            advance        = 1'($urandom_range(0, 1));
            step();
        end
        imem_req_ready = 1'b0;
        for (int j = 0; j <= rsp_wait; j++) begin
            check("wait_reqv",   imem_req_valid, 64'd0);
            check("wait_ivalid", instr_valid,    64'd0);
            imem_rsp_valid = (j == rsp_wait);
            imem_rsp_data  = (j == rsp_wait) ? data : $urandom;
            advance        = 1'($urandom_range(0, 1));
            step();
        end
        imem_rsp_valid = 1'b0;
        advance        = 1'b0;
        exp_instr      = data;
        check("hold_ivalid", instr_valid, 64'd1);
        check("hold_instr",  Instruction, data);
        check("hold_pc",     CurrentPC,   exp_pc);
    endtask

    // Stay in HOLD for a while with noise, then advance to npc
    task automatic hold_and_advance(input int hold_cycles, input logic [63:0] npc);
        for (int k = 0; k < hold_cycles; k++) begin
            advance        = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            imem_req_ready = 1'($urandom_range(0, 1));
            NextPC         = {$urandom, $urandom};
            step();
            check("stay_ivalid", instr_valid, 64'd1);
            check("stay_instr",  Instruction, exp_instr);
            check("stay_pc",     CurrentPC,   exp_pc);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        advance        = 1'b1;
        NextPC         = npc;
        step();
        advance = 1'b0;
        exp_pc  = npc;
        check("adv_ivalid", instr_valid,    64'd0);
        check("adv_pc",     CurrentPC,      npc);
        check("adv_addr",   imem_addr,      npc);
        check("adv_reqv",   imem_req_valid, 64'(npc[1:0] == 2'b00));
    endtask

    // Request accepted at once, then no response ever arrives
    task automatic do_timeout();
        check("to_reqv", imem_req_valid, 64'd1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            imem_rsp_valid = 1'b0;
            advance        = 1'($urandom_range(0, 1));
            step();
            check("to_flag",   timeout,     64'(k == 255));
            check("to_ivalid", instr_valid, 64'd0);
        end
        for (int k = 0; k < 4; k++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            imem_req_ready = 1'b1;
            advance        = 1'b1;
            step();
            check("err_tmo",    timeout,        64'd1);
            check("err_ivalid", instr_valid,    64'd0);
            check("err_reqv",   imem_req_valid, 64'd0);
            check("err_instr",  Instruction,    exp_instr);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        advance        = 1'b0;
    endtask

    initial begin
        logic [63:0] npc;
        resetl         = 1'b0;
        startPC        = '0;
        NextPC         = '0;
        advance        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        exp_pc         = '0;
        exp_instr      = '0;

        // First fetch from 0: instr_valid on the third edge after release
        do_reset(64'd0, 1'b0);
        do_fetch(0, 0, 32'h8B02_0020);

        // Advance to 0x10, minimum latency
        hold_and_advance(1, 64'h10);
        do_fetch(0, 0, $urandom);

        // Ready held low for 5 cycles
        hold_and_advance(2, {$urandom, $urandom} & ~64'h3);
        do_fetch(5, 1, $urandom);

        // Randomized fetches, including the top of the address space
        for (int n = 0; n < 20; n++) begin
            npc = (n == 7) ? 64'hFFFF_FFFF_FFFF_FFFC : ({$urandom, $urandom} & ~64'h3);
            hold_and_advance($urandom_range(0, 3), npc);
            do_fetch($urandom_range(0, 3), $urandom_range(0, 4), $urandom);
        end

        // Response on the 255th wait cycle still completes normally
        hold_and_advance(1, {$urandom, $urandom} & ~64'h3);
        do_fetch(0, 254, $urandom);

        // No response at all: timeout
        hold_and_advance(1, {$urandom, $urandom} & ~64'h3);
        do_timeout();

        // Misaligned NextPC: no request, sticky error until reset
        do_reset({$urandom, $urandom} & ~64'h3, 1'b0);
        do_fetch(1, 2, $urandom);
        hold_and_advance(1, 64'h6);
        step();
        check("mis_flag", misaligned,     64'd1);
        check("mis_reqv", imem_req_valid, 64'd0);
        for (int k = 0; k < 5; k++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            advance        = 1'b1;
            NextPC         = 64'h100;
            step();
            check("mis_stay",   misaligned,     64'd1);
            check("mis_ivalid", instr_valid,    64'd0);
            check("mis_reqv2",  imem_req_valid, 64'd0);
            check("mis_pc",     CurrentPC,      64'h6);
            check("mis_tmo",    timeout,        64'd0);
        end

        // Reset asserted mid-wait with a stale response around release
        do_reset(64'h40, 1'b0);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        #2;
        do_reset(64'h80, 1'b1);
        do_fetch(0, 1, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
